// File: rtl/fetch_buffer_pkg.sv
// Shared RV32I fetch definitions: reset PC default, opcode constants and the FIFO entry type.
package fetch_buffer_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_OP_IMM = 7'h13;
    localparam logic [6:0] OPC_LUI    = 7'h37;
    localparam logic [6:0] OPC_JAL    = 7'h6F;
    localparam logic [1:0] RV32_QUAD  = 2'b11;

    // Packed so that {pc, instr} maps onto a 64-bit FIFO word.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    function automatic logic is_rv32(input logic [31:0] instr);
        return instr[1:0] == RV32_QUAD;
    endfunction

endpackage

// File: rtl/fetch_buffer_if.sv
// Instruction memory and decode-side handshake bundle of the fetch stage.
interface fetch_buffer_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [6:0]  out_opcode;
    logic        out_illegal;

    modport master (
        output imem_req, imem_addr, out_valid, out_instr, out_pc, out_opcode, out_illegal,
        input  imem_rdata, redirect, redirect_pc, out_ready
    );

    modport slave (
        input  imem_req, imem_addr, out_valid, out_instr, out_pc, out_opcode, out_illegal,
        output imem_rdata, redirect, redirect_pc, out_ready
    );
endinterface

// File: rtl/fetch_fifo.sv
// Generic synchronous circular FIFO with flush; head is read combinationally from storage.
module fetch_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [PW-1:0] LastPtr = PW'(DEPTH - 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push, do_pop;

    assign full    = count_q == CW'(DEPTH);
    assign empty   = count_q == '0;
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_q <= (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: ;
            endcase
        end
    end

    // Storage needs no reset: contents are only observed while count is non-zero.
    always_ff @(posedge clk) begin
        if (do_push && !flush && !reset) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/fetch_buffer.sv
// Fetch stage: owns the PC, issues sequential word fetches and buffers responses for decode.
module fetch_buffer
    import fetch_buffer_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned DEPTH    = 3
) (
    input logic           clk,
    input logic           reset,
    fetch_buffer_if.master bus
);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [CW:0] DepthW = (CW + 1)'(DEPTH);

    logic [31:0]  pc_q, pc_d, inflight_pc_q, inflight_pc_d, redirect_target;
    logic         inflight_q, inflight_d, kill_q, kill_d;
    logic         issue, push, pop, fifo_full, fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [CW:0]  occupancy;
    logic [63:0]  fifo_rdata;
    fetch_entry_t wentry, head;

    always_comb begin
        redirect_target = bus.redirect_pc & ~32'h3;
        // Reserve a slot for every outstanding request so a response always has room.
        occupancy       = {1'b0, fifo_count} + {{CW{1'b0}}, inflight_q};
        issue           = !reset && !bus.redirect && (occupancy < DepthW);
        pop             = !fifo_empty && bus.out_ready;
        push            = inflight_q && !kill_q && !bus.redirect && (!fifo_full || pop);
        wentry          = '{pc: inflight_pc_q, instr: bus.imem_rdata};

        pc_d            = pc_q;
        inflight_pc_d   = inflight_pc_q;
        inflight_d      = issue;
        kill_d          = 1'b0;
        if (bus.redirect) begin
            pc_d   = redirect_target;
            kill_d = inflight_q;
        end else if (issue) begin
            pc_d          = pc_q + 32'd4;
            inflight_pc_d = pc_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q          <= RESET_PC;
            inflight_pc_q <= '0;
            inflight_q    <= 1'b0;
            kill_q        <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            inflight_pc_q <= inflight_pc_d;
            inflight_q    <= inflight_d;
            kill_q        <= kill_d;
        end
    end

    fetch_fifo #(
        .WIDTH (64),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (bus.redirect),
        .wdata (wentry),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign head            = fifo_empty ? '0 : fetch_entry_t'(fifo_rdata);
    assign bus.imem_req    = issue;
    assign bus.imem_addr   = pc_q;
    assign bus.out_valid   = !fifo_empty;
    assign bus.out_instr   = head.instr;
    assign bus.out_pc      = head.pc;
    assign bus.out_opcode  = head.instr[6:0];
    assign bus.out_illegal = !fifo_empty && !is_rv32(head.instr);

endmodule

// File: tb/tb_fetch_buffer.sv
// Scoreboard bench for fetch_buffer: synchronous memory model plus expected {pc, instr} queue.
module tb_fetch_buffer;
    import fetch_buffer_pkg::*;

    localparam int unsigned DEPTH    = 3;
    localparam logic [31:0] RESET_PC = RESET_PC_DEFAULT;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic [31:0] rdata_q = 32'h0;

    int tests_run    = 0;
    int tests_failed = 0;
    int delivered    = 0;
    fetch_entry_t exp_q[$];

    fetch_buffer_if bus ();

    fetch_buffer #(
        .RESET_PC (RESET_PC),
        .DEPTH    (DEPTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        if (addr == 32'h0)   return 32'h0050_0093;
        if (addr == 32'h200) return 32'h0000_0000;
        return {addr[13:2], 5'd0, 3'b000, 5'd1, OPC_OP_IMM};
    endfunction

    always @(posedge clk) begin
        if (bus.imem_req) rdata_q <= mem_word(bus.imem_addr);
        else              rdata_q <= 32'hDEAD_BEEF;
    end
    assign bus.imem_rdata = rdata_q;

    task automatic expect_from(input logic [31:0] start, input int n);
        logic [31:0] a;
        a = start;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(fetch_entry_t'{pc: a, instr: mem_word(a)});
            a = a + 32'd4;
        end
    endtask

    // Scoreboard consumer: called mid-cycle, compares any handshake, then moves to the next cycle.
    task automatic next_cycle();
        fetch_entry_t e;
        if (!reset && bus.out_valid && bus.out_ready && !bus.redirect) begin
            delivered++;
            tests_run++;
            if (exp_q.size() == 0) begin
                tests_failed++;
                $display("FAIL sb_unexpected: got pc=%h instr=%h, required no delivery",
                         bus.out_pc, bus.out_instr);
            end else begin
                e = exp_q.pop_front();
                if (bus.out_pc !== e.pc || bus.out_instr !== e.instr) begin
                    tests_failed++;
                    $display("FAIL sb_entry: got pc=%h instr=%h, required pc=%h instr=%h",
                             bus.out_pc, bus.out_instr, e.pc, e.instr);
                end
            end
        end
        if (!reset) assert (int'(dut.fifo_count) <= int'(DEPTH)) else $error("count above depth");
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.redirect = 1'b0;
        exp_q.delete();
        repeat (2) begin
            #1;
            next_cycle();
        end
        reset = 1'b0;
        delivered = 0;
    endtask

    task automatic test_reset();
        bus.out_ready = 1'b1;
        reset = 1'b1;
        exp_q.delete();
        for (int i = 0; i < 3; i++) begin
            #1;
            tests_run++;
            if (bus.imem_req !== 1'b0) begin
                tests_failed++;
                $display("FAIL reset_req: got %b, required 0", bus.imem_req);
            end
            if (i > 0) begin
                tests_run++;
                if ({bus.out_valid, bus.out_instr, bus.out_pc, bus.out_opcode, bus.out_illegal}
                    !== 73'h0) begin
                    tests_failed++;
                    $display("FAIL reset_outs: got valid=%b instr=%h pc=%h op=%h ill=%b, required 0",
                             bus.out_valid, bus.out_instr, bus.out_pc, bus.out_opcode,
                             bus.out_illegal);
                end
            end
            next_cycle();
        end
        reset = 1'b0;
        delivered = 0;
        expect_from(RESET_PC, 1);
        #1;
        tests_run++;
        if ({bus.imem_req, bus.imem_addr} !== {1'b1, RESET_PC}) begin
            tests_failed++;
            $display("FAIL c0_req: got req=%b addr=%h, required req=1 addr=%h",
                     bus.imem_req, bus.imem_addr, RESET_PC);
        end
        next_cycle();
        #1;
        tests_run++;
        if (bus.out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL c1_valid: got %b, required 0", bus.out_valid);
        end
        next_cycle();
        #1;
        tests_run++;
        if ({bus.out_valid, bus.out_instr, bus.out_pc, bus.out_opcode, bus.out_illegal} !==
            {1'b1, 32'h0050_0093, RESET_PC, OPC_OP_IMM, 1'b0}) begin
            tests_failed++;
            $display("FAIL c2_head: got valid=%b instr=%h pc=%h op=%h ill=%b, required 1 00500093 %h 13 0",
                     bus.out_valid, bus.out_instr, bus.out_pc, bus.out_opcode, bus.out_illegal,
                     RESET_PC);
        end
        next_cycle();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_stream();
        bus.out_ready = 1'b1;
        do_reset();
        expect_from(RESET_PC, 9);
        for (int c = 0; c < 11; c++) begin
            #1;
            if (c >= 2) begin
                tests_run++;
                if (bus.out_valid !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL stream_bubble: cycle %0d got valid=%b, required 1", c,
                             bus.out_valid);
                end
            end
            next_cycle();
        end
        bus.out_ready = 1'b0;
        tests_run++;
        if (delivered !== 9) begin
            tests_failed++;
            $display("FAIL stream_count: got %0d, required 9", delivered);
        end
    endtask

    task automatic test_backpressure();
        bus.out_ready = 1'b0;
        do_reset();
        expect_from(RESET_PC, 6);
        for (int c = 0; c < 10; c++) begin
            #1;
            if (c >= 2) begin
                tests_run++;
                if ({bus.out_valid, bus.out_pc, bus.out_instr} !==
                    {1'b1, RESET_PC, mem_word(RESET_PC)}) begin
                    tests_failed++;
                    $display("FAIL bp_head_frozen: cycle %0d got valid=%b pc=%h instr=%h", c,
                             bus.out_valid, bus.out_pc, bus.out_instr);
                end
            end
            if (c == 9) begin
                tests_run++;
                if (int'(dut.fifo_count) !== 3 || bus.imem_req !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL bp_full: got count=%0d req=%b, required count=3 req=0",
                             dut.fifo_count, bus.imem_req);
                end
            end
            next_cycle();
        end
        bus.out_ready = 1'b1;
        for (int p = 0; p < 6; p++) begin
            #1;
            if (p == 0) begin
                tests_run++;
                if (bus.imem_req !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL bp_first_pop_req: got %b, required 0", bus.imem_req);
                end
            end
            if (p == 1) begin
                tests_run++;
                if ({bus.imem_req, bus.imem_addr} !== {1'b1, RESET_PC + 32'hC}) begin
                    tests_failed++;
                    $display("FAIL bp_resume: got req=%b addr=%h, required req=1 addr=%h",
                             bus.imem_req, bus.imem_addr, RESET_PC + 32'hC);
                end
            end
            next_cycle();
        end
        bus.out_ready = 1'b0;
        tests_run++;
        if (delivered !== 6) begin
            tests_failed++;
            $display("FAIL bp_count: got %0d, required 6", delivered);
        end
    endtask

    task automatic test_redirect();
        bus.out_ready = 1'b1;
        do_reset();
        expect_from(RESET_PC, 2);
        repeat (4) begin
            #1;
            next_cycle();
        end
        bus.redirect = 1'b1;
        bus.redirect_pc = 32'h0000_0103;
        #1;
        tests_run++;
        if (dut.inflight_q !== 1'b1 || bus.imem_req !== 1'b0) begin
            tests_failed++;
            $display("FAIL rd_cycle: got inflight=%b req=%b, required inflight=1 req=0",
                     dut.inflight_q, bus.imem_req);
        end
        exp_q.delete();
        expect_from(32'h100, 3);
        next_cycle();
        bus.redirect = 1'b0;
        #1;
        tests_run++;
        if ({bus.imem_req, bus.imem_addr, bus.out_valid} !== {1'b1, 32'h100, 1'b0}) begin
            tests_failed++;
            $display("FAIL rd_r1: got req=%b addr=%h valid=%b, required req=1 addr=00000100 valid=0",
                     bus.imem_req, bus.imem_addr, bus.out_valid);
        end
        next_cycle();
        #1;
        tests_run++;
        if (bus.out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL rd_r2: got valid=%b, required 0", bus.out_valid);
        end
        next_cycle();
        #1;
        tests_run++;
        if ({bus.out_valid, bus.out_pc} !== {1'b1, 32'h100}) begin
            tests_failed++;
            $display("FAIL rd_r3: got valid=%b pc=%h, required valid=1 pc=00000100",
                     bus.out_valid, bus.out_pc);
        end
        next_cycle();
        repeat (2) begin
            #1;
            next_cycle();
        end
        bus.out_ready = 1'b0;
        tests_run++;
        if (delivered !== 5) begin
            tests_failed++;
            $display("FAIL rd_count: got %0d, required 5", delivered);
        end
    endtask

    task automatic test_simultaneous();
        bus.out_ready = 1'b1;
        do_reset();
        expect_from(RESET_PC, 1);
        repeat (3) begin
            #1;
            next_cycle();
        end
        bus.redirect = 1'b1;
        bus.redirect_pc = 32'h40;
        #1;
        tests_run++;
        if ({bus.out_valid, bus.out_pc} !== {1'b1, RESET_PC + 32'h4}) begin
            tests_failed++;
            $display("FAIL sim_pop: got valid=%b pc=%h, required valid=1 pc=%h",
                     bus.out_valid, bus.out_pc, RESET_PC + 32'h4);
        end
        exp_q.delete();
        next_cycle();
        bus.redirect_pc = 32'h80;
        #1;
        tests_run++;
        if ({bus.out_valid, bus.imem_req} !== 2'b00) begin
            tests_failed++;
            $display("FAIL sim_second: got valid=%b req=%b, required 0 0",
                     bus.out_valid, bus.imem_req);
        end
        expect_from(32'h80, 2);
        next_cycle();
        bus.redirect = 1'b0;
        #1;
        tests_run++;
        if ({bus.imem_req, bus.imem_addr, bus.out_valid} !== {1'b1, 32'h80, 1'b0}) begin
            tests_failed++;
            $display("FAIL sim_req: got req=%b addr=%h valid=%b, required req=1 addr=00000080 valid=0",
                     bus.imem_req, bus.imem_addr, bus.out_valid);
        end
        next_cycle();
        #1;
        tests_run++;
        if (bus.out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL sim_gap: got valid=%b, required 0", bus.out_valid);
        end
        next_cycle();
        #1;
        tests_run++;
        if ({bus.out_valid, bus.out_pc} !== {1'b1, 32'h80}) begin
            tests_failed++;
            $display("FAIL sim_first: got valid=%b pc=%h, required valid=1 pc=00000080",
                     bus.out_valid, bus.out_pc);
        end
        next_cycle();
        #1;
        next_cycle();
        bus.out_ready = 1'b0;
        tests_run++;
        if (delivered !== 3) begin
            tests_failed++;
            $display("FAIL sim_count: got %0d, required 3", delivered);
        end
    endtask

    task automatic test_illegal_wrap();
        bus.out_ready = 1'b1;
        do_reset();
        bus.redirect = 1'b1;
        bus.redirect_pc = 32'h200;
        expect_from(32'h200, 1);
        #1;
        next_cycle();
        bus.redirect = 1'b0;
        repeat (2) begin
            #1;
            next_cycle();
        end
        #1;
        tests_run++;
        if ({bus.out_valid, bus.out_pc, bus.out_illegal, bus.out_opcode} !==
            {1'b1, 32'h200, 1'b1, 7'h00}) begin
            tests_failed++;
            $display("FAIL illegal: got valid=%b pc=%h ill=%b op=%h, required 1 00000200 1 00",
                     bus.out_valid, bus.out_pc, bus.out_illegal, bus.out_opcode);
        end
        next_cycle();
        bus.redirect = 1'b1;
        bus.redirect_pc = 32'hFFFF_FFFC;
        exp_q.delete();
        expect_from(32'hFFFF_FFFC, 2);
        #1;
        next_cycle();
        bus.redirect = 1'b0;
        #1;
        tests_run++;
        if ({bus.imem_req, bus.imem_addr} !== {1'b1, 32'hFFFF_FFFC}) begin
            tests_failed++;
            $display("FAIL wrap_req_top: got req=%b addr=%h, required req=1 addr=fffffffc",
                     bus.imem_req, bus.imem_addr);
        end
        next_cycle();
        #1;
        tests_run++;
        if ({bus.imem_req, bus.imem_addr} !== {1'b1, 32'h0}) begin
            tests_failed++;
            $display("FAIL wrap_req_zero: got req=%b addr=%h, required req=1 addr=00000000",
                     bus.imem_req, bus.imem_addr);
        end
        next_cycle();
        #1;
        tests_run++;
        if ({bus.out_valid, bus.out_pc, bus.out_illegal} !== {1'b1, 32'hFFFF_FFFC, 1'b0}) begin
            tests_failed++;
            $display("FAIL wrap_head_top: got valid=%b pc=%h ill=%b, required 1 fffffffc 0",
                     bus.out_valid, bus.out_pc, bus.out_illegal);
        end
        next_cycle();
        #1;
        tests_run++;
        if ({bus.out_valid, bus.out_pc} !== {1'b1, 32'h0}) begin
            tests_failed++;
            $display("FAIL wrap_head_zero: got valid=%b pc=%h, required 1 00000000",
                     bus.out_valid, bus.out_pc);
        end
        next_cycle();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        bus.out_ready = 1'b0;
        do_reset();
        repeat (3) begin
            #1;
            next_cycle();
        end
        #1;
        tests_run++;
        if (int'(dut.fifo_count) !== 2) begin
            tests_failed++;
            $display("FAIL mid_count: got %0d, required 2", dut.fifo_count);
        end
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        bus.out_ready = 1'b1;
        delivered = 0;
        expect_from(RESET_PC, 2);
        #1;
        tests_run++;
        if ({bus.out_valid, bus.imem_req, bus.imem_addr} !== {1'b0, 1'b1, RESET_PC}) begin
            tests_failed++;
            $display("FAIL mid_after: got valid=%b req=%b addr=%h, required valid=0 req=1 addr=%h",
                     bus.out_valid, bus.imem_req, bus.imem_addr, RESET_PC);
        end
        next_cycle();
        #1;
        tests_run++;
        if (bus.out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_gap: got valid=%b, required 0", bus.out_valid);
        end
        next_cycle();
        #1;
        tests_run++;
        if ({bus.out_valid, bus.out_pc} !== {1'b1, RESET_PC}) begin
            tests_failed++;
            $display("FAIL mid_first: got valid=%b pc=%h, required valid=1 pc=%h",
                     bus.out_valid, bus.out_pc, RESET_PC);
        end
        next_cycle();
        #1;
        next_cycle();
        bus.out_ready = 1'b0;
        tests_run++;
        if (delivered !== 2) begin
            tests_failed++;
            $display("FAIL mid_delivered: got %0d, required 2", delivered);
        end
    endtask

    initial begin
        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'h0;
        bus.out_ready   = 1'b0;
        @(negedge clk);
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_simultaneous();
        test_illegal_wrap();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/fetch_buffer.md
# fetch_buffer

Instruction fetch stage with a small prefetch FIFO, sitting directly upstream of the opcode decoder and control unit. It owns the PC and issues sequential word fetches to the synchronous instruction memory. It buffers the returned words and presents them to decode with a valid/ready handshake. On a redirect from branch/jump resolution it flushes the buffer, discards in-flight data and restarts fetch at the new PC.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- `DEPTH`, default 3: FIFO entries. Minimum 2; 3 is required for one instruction per cycle.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `reset`, in, 1: synchronous, active-high.
- `imem_req`, out, 1: fetch request this cycle.
- `imem_addr`, out, 32: word-aligned fetch address (bits [1:0] = 0).
- `imem_rdata`, in, 32: instruction word, valid in the cycle after `imem_req`.
- `redirect`, in, 1: flush and restart fetch.
- `redirect_pc`, in, 32: new PC. Bits [1:0] are ignored (forced to 0).
- `out_valid`, out, 1: FIFO head is valid.
- `out_ready`, in, 1: decode accepts the head.
- `out_instr`, out, 32: head instruction.
- `out_pc`, out, 32: address of the head instruction.
- `out_opcode`, out, 7: `out_instr[6:0]`; drives the control unit opcode input.
- `out_illegal`, out, 1: head has `instr[1:0] != 2'b11` (not a 32-bit RV32I encoding).

## Operation
- **State:**
  - `pc`: next fetch address.
  - `inflight`: 1 bit, request issued last cycle.
  - `inflight_pc`.
  - `kill`: 1 bit, discard the in-flight response.
  - FIFO of {instr, pc} with `count` 0..DEPTH.
- **Issue rule:** `imem_req = !reset && !redirect && (count + inflight < DEPTH)`.
  - `imem_addr = pc`.
  - On issue: `pc <= pc + 4`, `inflight <= 1`, `inflight_pc <= pc`. Otherwise `inflight <= 0`.
- **Push:** when `inflight && !kill && !redirect`, push {`imem_rdata`, `inflight_pc`}.
  - Overflow is impossible by the issue rule. The bench asserts `count <= DEPTH`.
- **Pop:** when `out_valid && out_ready`. Push and pop in the same cycle leave `count` unchanged.
- **Redirect (highest priority):**
  - `count <= 0`.
  - `pc <= {redirect_pc[31:2], 2'b00}`.
  - `kill <= inflight`.
  - No request is issued in the redirect cycle.
  - A simultaneous pop is treated as consumed; no stale entry survives.
- **Kill:** the response arriving while `kill = 1` is dropped. `kill` clears in that same cycle.
  - Back-to-back redirects: the last one wins. `kill` is recomputed from `inflight` each time.
- **PC wrap:** 32'hFFFF_FFFC + 4 wraps to 0 with no flag.

## Timing
- **Reset values:**
  - `pc = RESET_PC`; `count = 0`; `inflight = 0`; `kill = 0`.
  - `out_valid = 0`; `imem_req = 0` during reset.
  - `out_instr`, `out_pc`, `out_opcode` = 0.
  - `out_illegal = 0`.
- Reset mid-operation discards all FIFO contents and any in-flight response on the next edge.
- **Fetch latency:** request in cycle N, data in N+1, pushed at the end of N+1, `out_valid` in N+2.
- **After reset deasserts** (first non-reset cycle = C0): request to `RESET_PC` in C0, `out_valid` in C2.
- **Redirect** asserted in cycle R:
  - request to the new PC in R+1;
  - `out_valid` for it in R+3;
  - `out_valid = 0` in R+1 and R+2.
- **Throughput:** with `DEPTH = 3` and `out_ready` held high, one instruction per cycle in steady state.
- **Stall behaviour:** with `out_ready` low, the FIFO fills to DEPTH and `imem_req` drops.
  - Fetch resumes in the cycle after the first pop.
- **Handshake:** the head is stable while `out_valid && !out_ready` (no change unless `redirect` or `reset`).
- `out_*` are FIFO head registers/mux outputs. There is no combinational path from `imem_rdata` to `out_*`.

## Structure
- **Shared defines** (existing RV32I defines include): `RESET_PC` default and the opcode constants used by `out_illegal` and the bench.
- **Sub-module `fetch_fifo`:** generic synchronous FIFO.
  - Parameters: `WIDTH`, `DEPTH`.
  - Ports: push, pop, flush, full, empty, count.
  - Instantiated with WIDTH = 64 ({pc, instr}).
- **Top level:** PC, inflight/kill, issue logic.

## Test plan
- **Reset and first fetch:** reset for 3 cycles, `RESET_PC = 0`, memory word 0 = 32'h00500093, `out_ready = 1` -> `imem_req` in C0 with addr 0; `out_valid` in C2 with `out_instr = 32'h00500093`, `out_pc = 0`, `out_opcode = 7'h13`.
- **Streaming:** addresses 0..0x20 hold sequential `addi`s, `out_ready = 1` -> after fill, `out_pc` advances by 4 every cycle with no bubbles.
- **Backpressure:** `out_ready = 0` for 10 cycles -> `count` reaches 3, `imem_req = 0`, head frozen. Release -> entries pop in order with no loss or duplication.
- **Redirect with in-flight:** `redirect = 1`, `redirect_pc = 32'h0000_0103` while `inflight = 1` -> next request addr 0x100; killed response never appears; `out_valid` with `out_pc = 0x100` exactly 3 cycles after redirect.
- **Simultaneous events:** redirect + pop in one cycle, and two redirects in consecutive cycles (0x40 then 0x80) -> first delivered `out_pc = 0x80`, no 0x40 entry.
- **Illegal/wrap/reset mid-stream:**
  - word 32'h0000_0000 -> `out_illegal = 1`.
  - redirect to 0xFFFF_FFFC -> next `out_pc` values 0xFFFF_FFFC then 0.
  - reset asserted with `count = 2` -> `out_valid = 0` next cycle and `pc = RESET_PC`.
